// File: rtl/ula_pkg.sv
// Shared definitions for the serial-nibble ALU: nibble width, controller
// state encoding and named 74181 function selects.
package ula_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Mode values for m
  localparam logic M_ARITH = 1'b0;
  localparam logic M_LOGIC = 1'b1;

  // Common function selects (pair with the mode noted)
  localparam logic [3:0] S_ADD  = 4'b1001;  // m = 0 : A plus B plus carry
  localparam logic [3:0] S_XOR  = 4'b0110;  // m = 1 : A xor B
  localparam logic [3:0] S_XNOR = 4'b1001;  // m = 1 : A xnor B

endpackage

// File: rtl/ula_74181.sv
// Combinational 4-bit 74181-style ALU slice, active-high data and an
// active-high carry in / carry out. a_eq_b is high when f is all ones.
module ula_74181
  import ula_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic [3:0]          s,
  input  logic                m,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] f,
  output logic                c_out,
  output logic                a_eq_b
);

  logic [NIBBLE_W-1:0] t1;
  logic [NIBBLE_W-1:0] t2;
  logic [NIBBLE_W:0]   sum;
  logic [NIBBLE_W-1:0] logic_f;

  // Arithmetic path: every 74181 arithmetic function is t1 plus t2 plus carry
  always_comb begin
    t1  = a | (b & {NIBBLE_W{s[0]}}) | (~b & {NIBBLE_W{s[1]}});
    t2  = (a & ~b & {NIBBLE_W{s[2]}}) | (a & b & {NIBBLE_W{s[3]}});
    sum = {1'b0, t1} + {1'b0, t2} + {{NIBBLE_W{1'b0}}, c_in};
  end

  // Logic path: the sixteen bitwise functions selected by s
  always_comb begin
    logic_f = '0;
    case (s)
      4'b0000: logic_f = ~a;
      4'b0001: logic_f = ~(a | b);
      4'b0010: logic_f = ~a & b;
      4'b0011: logic_f = '0;
      4'b0100: logic_f = ~(a & b);
      4'b0101: logic_f = ~b;
      4'b0110: logic_f = a ^ b;
      4'b0111: logic_f = a & ~b;
      4'b1000: logic_f = ~a | b;
      4'b1001: logic_f = ~(a ^ b);
      4'b1010: logic_f = b;
      4'b1011: logic_f = a & b;
      4'b1100: logic_f = '1;
      4'b1101: logic_f = a | ~b;
      4'b1110: logic_f = a | b;
      default: logic_f = a;
    endcase
  end

  // Mode mux; the carry chain keeps running in logic mode
  always_comb begin
    f      = m ? logic_f : sum[NIBBLE_W-1:0];
    c_out  = sum[NIBBLE_W];
    a_eq_b = &f;
  end

endmodule

// File: rtl/ula_serial_nibble.sv
// Wide 74181-style ALU built by stepping one ula_74181 slice across NIBBLES
// nibbles, LSB first, with a start/busy/done handshake.
// Optional build macro ULA_ZERO_FLAG_EN adds a registered zero-result flag.
module ula_serial_nibble
  import ula_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b_in,
  input  logic [3:0]                   s_in,
  input  logic                         m_in,
  input  logic                         c_in,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  f_out,
  output logic                         c_out,
`ifdef ULA_ZERO_FLAG_EN
  output logic                         zero,
`endif
  output logic                         a_eq_b
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               eq_acc_q, eq_acc_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [3:0]         s_q, s_d;
  logic               m_q, m_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       f_out_q, f_out_d;
  logic               c_out_q, c_out_d;
  logic               a_eq_b_q, a_eq_b_d;
  logic               done_q, done_d;
`ifdef ULA_ZERO_FLAG_EN
  logic               zero_q, zero_d;
`endif

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [W-1:0]        work_merged;
  logic [NIBBLE_W-1:0] slice_f;
  logic                slice_c;
  logic                slice_eq;

  // Split latched operands into nibbles and build the working result with
  // the current slice output dropped into nibble idx
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
    assign work_merged[gi*NIBBLE_W +: NIBBLE_W] =
      (idx_q == IDX_W'(gi)) ? slice_f : work_q[gi*NIBBLE_W +: NIBBLE_W];
  end

  ula_74181 u_slice (
    .a      (a_nib[idx_q]),
    .b      (b_nib[idx_q]),
    .s      (s_q),
    .m      (m_q),
    .c_in   (carry_q),
    .f      (slice_f),
    .c_out  (slice_c),
    .a_eq_b (slice_eq)
  );

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      work_q   <= '0;
      f_out_q  <= '0;
      c_out_q  <= 1'b0;
      a_eq_b_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef ULA_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      eq_acc_q <= eq_acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      work_q   <= work_d;
      f_out_q  <= f_out_d;
      c_out_q  <= c_out_d;
      a_eq_b_q <= a_eq_b_d;
      done_q   <= done_d;
`ifdef ULA_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Next-state and datapath update: latch on start, step one nibble per
  // cycle in RUN, publish the wide result only on the last nibble
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    eq_acc_d = eq_acc_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    work_d   = work_q;
    f_out_d  = f_out_q;
    c_out_d  = c_out_q;
    a_eq_b_d = a_eq_b_q;
    done_d   = 1'b0;
`ifdef ULA_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          s_d      = s_in;
          m_d      = m_in;
          idx_d    = '0;
          carry_d  = c_in;
          eq_acc_d = 1'b1;
          state_d  = RUN;
        end
      end
      default: begin
        work_d   = work_merged;
        carry_d  = slice_c;
        eq_acc_d = eq_acc_q & slice_eq;
        if (idx_q == LAST_IDX) begin
          f_out_d  = work_merged;
          c_out_d  = slice_c;
          a_eq_b_d = eq_acc_q & slice_eq;
`ifdef ULA_ZERO_FLAG_EN
          zero_d   = (work_merged == '0);
`endif
          done_d   = 1'b1;
          idx_d    = '0;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  // Outputs straight from registers; busy is simply "in RUN"
  always_comb begin
    busy   = (state_q == RUN);
    done   = done_q;
    f_out  = f_out_q;
    c_out  = c_out_q;
    a_eq_b = a_eq_b_q;
`ifdef ULA_ZERO_FLAG_EN
    zero   = zero_q;
`endif
  end

endmodule

// File: tb/tb_ula_serial_nibble.sv
// Scoreboard bench for ula_serial_nibble (NIBBLES=4): the driver pushes
// hand-computed results, a negedge monitor pops one on every done pulse.
module tb_ula_serial_nibble;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [3:0]   s_in = '0;
  logic         m_in = 1'b0;
  logic         c_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] f_out;
  logic         c_out;
  logic         a_eq_b;
`ifdef ULA_ZERO_FLAG_EN
  logic         zero;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] f;
    logic         c;
    logic         eq;
  } exp_t;

  exp_t sb[$];
  int   done_times[$];

  ula_serial_nibble #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .s_in   (s_in),
    .m_in   (m_in),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .f_out  (f_out),
    .c_out  (c_out),
`ifdef ULA_ZERO_FLAG_EN
    .zero   (zero),
`endif
    .a_eq_b (a_eq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation on each done, otherwise checks outputs hold
  initial begin : monitor
    logic [W-1:0] last_f;
    logic         last_c;
    logic         last_eq;
    exp_t         e;
    last_f = '0; last_c = 1'b0; last_eq = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_f = f_out; last_c = c_out; last_eq = a_eq_b;
      end else if (done) begin
        done_times.push_back(cyc);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: cycle %0d f_out=%h, no result expected", cyc, f_out);
        end else begin
          e = sb.pop_front();
          check("f_out", 32'(f_out), 32'(e.f));
          check("c_out", 32'(c_out), 32'(e.c));
          check("a_eq_b", 32'(a_eq_b), 32'(e.eq));
`ifdef ULA_ZERO_FLAG_EN
          check("zero", 32'(zero), 32'(e.f == '0));
`endif
          $display("result: f_out=%h c_out=%0d a_eq_b=%0d at cycle %0d", f_out, c_out, a_eq_b, cyc);
        end
        last_f = f_out; last_c = c_out; last_eq = a_eq_b;
      end else begin
        check("hold", {15'd0, f_out, c_out}, {15'd0, last_f, last_c});
        last_f = f_out; last_c = c_out; last_eq = a_eq_b;
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] f, input logic c, input logic eq);
    exp_t e;
    e.f = f; e.c = c; e.eq = eq;
    sb.push_back(e);
  endtask

  // One start pulse; returns just after the accepting edge
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic c);
    @(posedge clk); #1;
    a_in = a; b_in = b; s_in = s; m_in = m; c_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for busy to fall; checks remaining busy cycles and done
  task automatic wait_done(input int exp_busy);
    int bc;
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      @(posedge clk); #1;
    end
    check("busy_len", 32'(bc), 32'(exp_busy));
    check("done_lat", 32'(done), 32'd1);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int base;
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_f_out", 32'(f_out), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_a_eq_b", 32'(a_eq_b), 32'd0);
    rst = 1'b0;

    // Add: 1234 + 0FCC = 2200
    push_exp(16'h2200, 1'b0, 1'b0);
    drive_op(16'h1234, 16'h0FCC, 4'b1001, 1'b0, 1'b0);
    wait_done(4);

    // Carry ripple: FFFF + 0001 = 0000 carry 1
    push_exp(16'h0000, 1'b1, 1'b0);
    drive_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    wait_done(4);

    // XOR in logic mode; carry chain computes A + ~B = 1_95B4
    push_exp(16'hAA55, 1'b1, 1'b0);
    drive_op(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b0);
    wait_done(4);

    // XNOR of equal operands; chain computes 5A5A + 5A5A = B4B4
    push_exp(16'hFFFF, 1'b0, 1'b1);
    drive_op(16'h5A5A, 16'h5A5A, 4'b1001, 1'b1, 1'b0);
    wait_done(4);

    // start during RUN with other operands is ignored
    push_exp(16'h0003, 1'b0, 1'b0);
    drive_op(16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b0);
    @(posedge clk); #1;
    a_in = 16'h1111; b_in = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2);
    repeat (8) @(posedge clk);
    #1;
    check("ignored_start_busy", 32'(busy), 32'd0);

    // start held high: accepted in each done cycle, period 5
    push_exp(16'h0030, 1'b0, 1'b0);
    push_exp(16'h0030, 1'b0, 1'b0);
    push_exp(16'h0030, 1'b0, 1'b0);
    base = done_times.size();
    @(posedge clk); #1;
    a_in = 16'h0010; b_in = 16'h0020; s_in = 4'b1001; m_in = 1'b0; c_in = 1'b0;
    start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (done_times.size() < base + 3 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("b2b_count", 32'(done_times.size() - base), 32'd3);
    if (done_times.size() >= base + 3) begin
      check("b2b_period1", 32'(done_times[base+1] - done_times[base]), 32'd5);
      check("b2b_period2", 32'(done_times[base+2] - done_times[base+1]), 32'd5);
    end
    repeat (2) @(posedge clk);

    // Reset abort at idx=2
    drive_op(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_f_out", 32'(f_out), 32'd0);
    check("abort_c_out", 32'(c_out), 32'd0);
    check("abort_a_eq_b", 32'(a_eq_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done), 32'd0);

    // Fresh add after abort
    push_exp(16'h0002, 1'b0, 1'b0);
    drive_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0);
    wait_done(4);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
